udp_rx_frame_buffer: RTL and testbench
======================================

Name: udp_rx_frame_buffer

Overview:
- Sits directly downstream of the GMII UDP receiver. Consumes its 32-bit packed payload words, write-address, frame counter and UDP length outputs.
- Stores each received UDP payload into one of two ping-pong pages of on-chip RAM.
- Presents complete frames to the CPU-side consumer through a valid/done handshake with a random-access word read port.

Parameters:
- ADDR_W, 9, word-address width per page; page depth = 2**ADDR_W words.
- LEN_W, 16, width of the UDP length field.

Ports:
- clk  in  1  receiver GMII clock, the block's only clock
- clr  in  1  asynchronous active-low reset
- in_data  in  32  packed payload word from receiver (data_o)
- in_wr_addr  in  ADDR_W  receiver word write address (ram_wr_addr); 0 between frames, first word of a frame = 1
- in_udp_len  in  LEN_W  UDP length field including 8-byte header (rx_data_length)
- in_frame_cnt  in  32  receiver frame-complete counter (receive_counter)
- rd_frame_valid  out  1  a committed frame is available
- rd_page  out  1  page index of the presented frame
- rd_len_bytes  out  LEN_W  payload byte count of the presented frame
- rd_word_cnt  out  ADDR_W+1  words stored for the presented frame
- rd_addr  in  ADDR_W  word read address within the presented frame
- rd_data  out  32  RAM word, 1-cycle latency after rd_addr
- rd_done  in  1  single-cycle pulse; consumer has finished the presented frame
- drop_cnt  out  16  frames dropped (both pages full, or oversize)
- trunc_flag  out  1  sticky; set on any oversize drop

Behaviour:
- Reset (clr low, async): every output is 0, both pages are empty, write page = 0, prev_addr = 0, prev_cnt is loaded from in_frame_cnt on the first clock after release, state = IDLE. RAM contents are don't-care.
- Word strobe:
  - Asserted when in_wr_addr != prev_addr and in_wr_addr != 0.
  - prev_addr is registered every cycle.
  - The receiver's data valid signal is not used because it is level-held.
- Frame-end strobe: asserted when in_frame_cnt != prev_cnt. prev_cnt is registered every cycle.
- State machine:
  - IDLE: on the first word strobe, go to FILL if the write page is empty, else go to DROP.
  - FILL:
    - Each word strobe writes in_data to RAM[wpage][in_wr_addr-1].
    - If in_wr_addr-1 >= 2**ADDR_W, go to DROP: increment drop_cnt, set trunc_flag, do not write.
    - On frame-end strobe, commit and go to IDLE.
    - If in_wr_addr returns to 0 without a frame-end strobe (receiver aborted), discard and go to IDLE. No drop_cnt change.
  - DROP:
    - On frame-end strobe, increment drop_cnt (only if not already counted for oversize), then go to IDLE.
    - If in_wr_addr returns to 0, go to IDLE.
- A frame-end strobe and a word strobe in the same cycle: the word is written first, then the commit includes it.
- Commit:
  - Mark page wpage full.
  - Store len = in_udp_len - 8, saturating to 0 if in_udp_len < 8.
  - Store words = last in_wr_addr.
  - Toggle wpage.
- Read side:
  - The oldest full page is presented. Commit order is tracked with a 1-bit head pointer.
  - rd_frame_valid, rd_page, rd_len_bytes and rd_word_cnt are registered and update the cycle after commit or release.
  - rd_done while rd_frame_valid is high: clear the head page, advance head, drop rd_frame_valid next cycle. If the other page is full, it is presented 1 cycle later.
  - rd_done while rd_frame_valid is low is ignored.
- A commit and rd_done in the same cycle are both applied; page accounting never loses a frame.
- drop_cnt saturates at 16'hFFFF.
- rd_addr >= rd_word_cnt returns undefined data; no error is raised.

Test Plan:
- Frame of in_udp_len=20 (12 payload bytes, addr 1..3, words 0x11223344, 0x55667788, 0x99AABBCC), then frame_cnt 0->1 -> rd_frame_valid=1, rd_len_bytes=12, rd_word_cnt=3, rd_addr 0..2 returns those words 1 cycle later.
- Three frames back-to-back with no rd_done -> frames 1 and 2 fill pages 0/1, frame 3 dropped, drop_cnt=1. rd_done -> page 1 is presented with frame 2 contents.
- in_udp_len=13 (5 bytes, last word 0xEE000000, addr reaches 2) -> rd_word_cnt=2, rd_len_bytes=5, word1=0xEE000000.
- Frame-end strobe coincident with the final word strobe -> final word stored, rd_word_cnt correct.
- Address exceeding 512 words -> frame dropped, trunc_flag=1, page stays empty, the next normal frame is accepted.
- clr pulsed low mid-FILL -> outputs 0 immediately, no frame presented, the next frame is received correctly into page 0.

Source files
------------

// File: rtl/udp_rx_frame_buffer.sv
// Ping-pong frame buffer that sits behind the GMII UDP receiver. It captures each
// payload into one of two RAM pages and hands whole frames to a CPU-side reader.
module udp_rx_frame_buffer #(
    parameter int ADDR_W = 9,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [31:0]       in_data,
    input  logic [ADDR_W-1:0] in_wr_addr,
    input  logic [LEN_W-1:0]  in_udp_len,
    input  logic [31:0]       in_frame_cnt,
    output logic              rd_frame_valid,
    output logic              rd_page,
    output logic [LEN_W-1:0]  rd_len_bytes,
    output logic [ADDR_W:0]   rd_word_cnt,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    input  logic              rd_done,
    output logic [15:0]       drop_cnt,
    output logic              trunc_flag
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DROP} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_prev_addr;
    logic [31:0]       r_prev_cnt;
    logic              r_cnt_vld;
    logic              r_wpage;
    logic              r_head;
    logic [1:0]        r_full;
    logic [LEN_W-1:0]  r_len   [2];
    logic [ADDR_W:0]   r_words [2];
    logic [ADDR_W-1:0] r_last;
    logic              r_ovf;
    logic [31:0]       r_mem   [0:2*DEPTH-1];

    logic              w_wstb, w_fend, w_fall, w_wrap, w_start;
    logic              w_in_frame, w_write, w_commit, w_oversize, w_cnt_drop, w_rel;
    logic [ADDR_W-1:0] w_waddr;
    logic [ADDR_W:0]   w_words;
    logic [LEN_W-1:0]  w_len;
    logic [1:0]        w_full_n;

    assign w_wstb  = (in_wr_addr != r_prev_addr) && (in_wr_addr != '0);
    assign w_fend  = r_cnt_vld && (in_frame_cnt != r_prev_cnt);
    assign w_fall  = (r_prev_addr != '0) && (in_wr_addr == '0);
    // The write address is only ADDR_W bits, so a frame longer than a page shows
    // up as the receiver address rolling over from all-ones back to zero.
    assign w_wrap  = (r_prev_addr == '1) && (in_wr_addr == '0);
    assign w_start = (r_state == S_IDLE) && w_wstb;

    // The first word of a frame arrives while still in IDLE and must be kept.
    assign w_in_frame = (r_state == S_FILL) || (w_start && !r_full[r_wpage]);
    assign w_write    = w_in_frame && w_wstb;
    assign w_commit   = w_in_frame && w_fend;
    assign w_oversize = (r_state == S_FILL) && !w_fend && w_wrap;
    assign w_cnt_drop = w_oversize
                      || (w_start && r_full[r_wpage] && w_fend)
                      || ((r_state == S_DROP) && w_fend && !r_ovf);
    assign w_rel      = rd_done && rd_frame_valid;

    assign w_waddr = in_wr_addr - ADDR_W'(1);
    assign w_words = w_wstb ? {1'b0, in_wr_addr} : {1'b0, r_last};
    assign w_len   = (in_udp_len < LEN_W'(8)) ? '0 : in_udp_len - LEN_W'(8);

    always_comb begin
        w_full_n = r_full;
        if (w_commit) w_full_n[r_wpage] = 1'b1;
        if (w_rel)    w_full_n[r_head]  = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_write) r_mem[{r_wpage, w_waddr}] <= in_data;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state        <= S_IDLE;
            r_prev_addr    <= '0;
            r_prev_cnt     <= '0;
            r_cnt_vld      <= 1'b0;
            r_wpage        <= 1'b0;
            r_head         <= 1'b0;
            r_full         <= '0;
            r_len          <= '{default: '0};
            r_words        <= '{default: '0};
            r_last         <= '0;
            r_ovf          <= 1'b0;
            rd_frame_valid <= 1'b0;
            rd_page        <= 1'b0;
            rd_len_bytes   <= '0;
            rd_word_cnt    <= '0;
            rd_data        <= '0;
            drop_cnt       <= '0;
            trunc_flag     <= 1'b0;
        end else begin
            r_prev_addr <= in_wr_addr;
            r_prev_cnt  <= in_frame_cnt;
            r_cnt_vld   <= 1'b1;
            rd_data     <= r_mem[{rd_page, rd_addr}];

            if (w_write) r_last <= in_wr_addr;

            case (r_state)
                S_IDLE: begin
                    if (w_start && !w_fend) begin
                        r_state <= r_full[r_wpage] ? S_DROP : S_FILL;
                        r_ovf   <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (w_fend || w_fall)
                        r_state <= S_IDLE;
                    if (w_oversize) begin
                        r_state <= S_DROP;
                        r_ovf   <= 1'b1;
                    end
                end
                S_DROP: begin
                    if (w_fend || w_fall) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_commit) begin
                r_len[r_wpage]   <= w_len;
                r_words[r_wpage] <= w_words;
                r_wpage          <= ~r_wpage;
            end
            r_full <= w_full_n;
            if (w_rel) r_head <= ~r_head;

            if (w_cnt_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (w_oversize) trunc_flag <= 1'b1;

            // Presentation regs track next-cycle page state; a release forces one
            // idle cycle before the other page (if full) is shown.
            if (w_rel) begin
                rd_frame_valid <= 1'b0;
                rd_page        <= ~r_head;
                rd_len_bytes   <= '0;
                rd_word_cnt    <= '0;
            end else begin
                rd_frame_valid <= w_full_n[r_head];
                rd_page        <= r_head;
                if (w_commit && r_wpage == r_head) begin
                    rd_len_bytes <= w_len;
                    rd_word_cnt  <= w_words;
                end else if (r_full[r_head]) begin
                    rd_len_bytes <= r_len[r_head];
                    rd_word_cnt  <= r_words[r_head];
                end else begin
                    rd_len_bytes <= '0;
                    rd_word_cnt  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_udp_rx_frame_buffer.sv
// Directed bench for udp_rx_frame_buffer: a frame table plus hand-written
// sequences for page-full drops, oversize, and mid-frame reset.
module tb_udp_rx_frame_buffer;
    localparam int AW = 9;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          clr;
    logic [31:0]   in_data;
    logic [AW-1:0] in_wr_addr;
    logic [LW-1:0] in_udp_len;
    logic [31:0]   in_frame_cnt;
    logic          rd_frame_valid;
    logic          rd_page;
    logic [LW-1:0] rd_len_bytes;
    logic [AW:0]   rd_word_cnt;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic          rd_done;
    logic [15:0]   drop_cnt;
    logic          trunc_flag;

    udp_rx_frame_buffer #(.ADDR_W(AW), .LEN_W(LW)) dut (
        .clk(clk), .clr(clr), .in_data(in_data), .in_wr_addr(in_wr_addr),
        .in_udp_len(in_udp_len), .in_frame_cnt(in_frame_cnt),
        .rd_frame_valid(rd_frame_valid), .rd_page(rd_page),
        .rd_len_bytes(rd_len_bytes), .rd_word_cnt(rd_word_cnt),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_done(rd_done),
        .drop_cnt(drop_cnt), .trunc_flag(trunc_flag)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int              len;
        int              n;
        logic [2:0][31:0] w;
        bit              coinc;
        int              exp_len;
        int              exp_wc;
    } fvec_t;

    fvec_t tbl[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int len, input int n, input logic [2:0][31:0] w, input bit coinc);
        in_udp_len = LW'(len);
        for (int i = 0; i < n; i++) begin
            in_wr_addr = AW'(i + 1);
            in_data    = w[i];
            if (coinc && i == n - 1) in_frame_cnt = in_frame_cnt + 32'd1;
            step();
        end
        if (!coinc) begin
            in_frame_cnt = in_frame_cnt + 32'd1;
            step();
        end
        in_wr_addr = '0;
        step();
    endtask

    task automatic read_word(input string name, input int a, input logic [31:0] exp);
        rd_addr = AW'(a);
        step();
        check(name, rd_data, exp);
    endtask

    task automatic release_frame();
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        check("valid_low_after_done", 32'(rd_frame_valid), 32'd0);
    endtask

    initial begin
        tbl[0] = '{len: 20, n: 3, w: {32'h99AABBCC, 32'h55667788, 32'h11223344}, coinc: 0, exp_len: 12, exp_wc: 3};
        tbl[1] = '{len: 13, n: 2, w: {32'h0, 32'hEE000000, 32'hDEADBEEF}, coinc: 0, exp_len: 5, exp_wc: 2};
        tbl[2] = '{len: 16, n: 2, w: {32'h0, 32'h05060708, 32'h01020304}, coinc: 1, exp_len: 8, exp_wc: 2};
        tbl[3] = '{len: 6,  n: 1, w: {32'h0, 32'h0, 32'hCAFEF00D}, coinc: 0, exp_len: 0, exp_wc: 1};

        clr = 1'b0; in_data = '0; in_wr_addr = '0; in_udp_len = '0;
        in_frame_cnt = 32'h55; rd_addr = '0; rd_done = 1'b0;
        step(); step();
        check("reset_valid", 32'(rd_frame_valid), 32'd0);
        check("reset_drop",  32'(drop_cnt), 32'd0);
        check("reset_trunc", 32'(trunc_flag), 32'd0);
        check("reset_wc",    32'(rd_word_cnt), 32'd0);
        clr = 1'b1;
        step(); step();
        check("post_reset_valid", 32'(rd_frame_valid), 32'd0);

        for (int i = 0; i < 4; i++) begin
            send_frame(tbl[i].len, tbl[i].n, tbl[i].w, tbl[i].coinc);
            check($sformatf("tbl%0d_valid", i), 32'(rd_frame_valid), 32'd1);
            check($sformatf("tbl%0d_page", i),  32'(rd_page), 32'(i % 2));
            check($sformatf("tbl%0d_len", i),   32'(rd_len_bytes), 32'(tbl[i].exp_len));
            check($sformatf("tbl%0d_wc", i),    32'(rd_word_cnt), 32'(tbl[i].exp_wc));
            for (int k = 0; k < tbl[i].n; k++)
                read_word($sformatf("tbl%0d_word%0d", i, k), k, tbl[i].w[k]);
            release_frame();
            step();
            check($sformatf("tbl%0d_empty", i), 32'(rd_frame_valid), 32'd0);
        end

        // Both pages full: third frame is dropped, second is shown after release.
        send_frame(16, 2, {32'h0, 32'hAAAA0002, 32'hAAAA0001}, 0);
        send_frame(20, 3, {32'hBBBB0003, 32'hBBBB0002, 32'hBBBB0001}, 0);
        send_frame(12, 1, {32'h0, 32'h0, 32'hCCCC0001}, 0);
        check("bb_drop_cnt", 32'(drop_cnt), 32'd1);
        check("bb_page0",    32'(rd_page), 32'd0);
        check("bb_len0",     32'(rd_len_bytes), 32'd8);
        read_word("bb_a_word1", 1, 32'hAAAA0002);
        release_frame();
        step();
        check("bb_valid1", 32'(rd_frame_valid), 32'd1);
        check("bb_page1",  32'(rd_page), 32'd1);
        check("bb_len1",   32'(rd_len_bytes), 32'd12);
        check("bb_wc1",    32'(rd_word_cnt), 32'd3);
        read_word("bb_b_word2", 2, 32'hBBBB0003);
        release_frame();
        step();
        check("bb_empty", 32'(rd_frame_valid), 32'd0);

        // Stray rd_done with nothing presented must not advance the head.
        rd_done = 1'b1; step(); rd_done = 1'b0; step();

        // Oversize: address rolls over past the page end.
        in_udp_len = 16'd1200;
        for (int i = 1; i < 512; i++) begin
            in_wr_addr = AW'(i);
            in_data    = 32'(i);
            step();
        end
        in_wr_addr = '0;
        step();
        check("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
        check("ovf_trunc",    32'(trunc_flag), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            in_wr_addr = AW'(i);
            step();
        end
        in_frame_cnt = in_frame_cnt + 32'd1;
        step();
        in_wr_addr = '0;
        step();
        check("ovf_no_frame",  32'(rd_frame_valid), 32'd0);
        check("ovf_drop_once", 32'(drop_cnt), 32'd2);
        send_frame(12, 1, {32'h0, 32'h0, 32'h12345678}, 0);
        check("post_ovf_valid", 32'(rd_frame_valid), 32'd1);
        check("post_ovf_page",  32'(rd_page), 32'd0);
        check("post_ovf_len",   32'(rd_len_bytes), 32'd4);
        check("post_ovf_wc",    32'(rd_word_cnt), 32'd1);
        read_word("post_ovf_word0", 0, 32'h12345678);

        // Reset pulsed mid-FILL of page 1 while page 0 is presented.
        in_udp_len = 16'd24;
        in_wr_addr = 9'd1; in_data = 32'hF0F0F0F0; step();
        in_wr_addr = 9'd2; in_data = 32'h0F0F0F0F; step();
        #2 clr = 1'b0;
        #1;
        check("clr_valid", 32'(rd_frame_valid), 32'd0);
        check("clr_drop",  32'(drop_cnt), 32'd0);
        check("clr_trunc", 32'(trunc_flag), 32'd0);
        check("clr_len",   32'(rd_len_bytes), 32'd0);
        in_wr_addr = '0;
        in_frame_cnt = in_frame_cnt + 32'd7;
        step(); step();
        clr = 1'b1;
        step(); step();
        check("clr_after_valid", 32'(rd_frame_valid), 32'd0);
        send_frame(20, 3, {32'h33333333, 32'h22222222, 32'h11111111}, 0);
        check("clr_frame_valid", 32'(rd_frame_valid), 32'd1);
        check("clr_frame_page",  32'(rd_page), 32'd0);
        check("clr_frame_len",   32'(rd_len_bytes), 32'd12);
        check("clr_frame_wc",    32'(rd_word_cnt), 32'd3);
        read_word("clr_frame_word0", 0, 32'h11111111);
        read_word("clr_frame_word2", 2, 32'h33333333);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
